ucie_ctl_sb_rx_msg_buf: RTL

Parametrised sideband receive path for the UCIe controller. It deserialises N-bit sideband beats into 64-bit-header messages, with an optional 64-bit payload, and checks source ID, destination ID, opcode, support and parity. Each completed message is decoded and stored in a DEPTH-entry buffer, which is drained with a valid/ready handshake toward the RDI sideband logic. Buffer entries are returned to the transmitter as credits.

---
 rtl/ucie_ctl_sb_rx_msg_buf.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ucie_ctl_sb_rx_msg_buf.sv
// UCIe sideband receive path: beat deserialiser, header checks, message decode and entry FIFO.
// Define UCIE_SB_RX_PARITY_CHK_EN to build the dp/cp parity checks; otherwise the parity flag is 0.
module ucie_ctl_sb_rx_msg_buf #(
    parameter int         N      = 16,
    parameter int         DEPTH  = 4,
    parameter logic [2:0] SRC_ID = 3'b001,
    parameter logic [2:0] DST_ID = 3'b101
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_pl_cfg_vld,
    input  logic [N-1:0]           i_received_data,
    input  logic                   i_msg_rdy,
    output logic                   o_msg_vld,
    output logic [4:0]             o_rdi_pl_sb_decode,
    output logic [63:0]            o_rdi_pl_adv_cap_value,
    output logic                   o_sb_src_error,
    output logic                   o_sb_dst_error,
    output logic                   o_sb_opcode_error,
    output logic                   o_sb_unsupported_message,
    output logic                   o_sb_parity_error,
    output logic                   o_cfg_crd,
    output logic                   o_sb_overflow,
    output logic [$clog2(DEPTH):0] o_fill
);

    localparam int BEATS_HDR = 64 / N;
    localparam int BEATS_MSG = 128 / N;
    localparam int CW        = $clog2(BEATS_MSG);
    localparam int AW        = $clog2(DEPTH);
    localparam int FW        = AW + 1;
    // Beat index and bit offset at which header opcode[4:0] (header bits 36:32) arrives.
    localparam int OP_BEAT   = 31 / N;
    localparam int OP_LSB    = (OP_BEAT + 1) * N - 32;

    localparam logic [4:0] OPC_NODATA = 5'b10010;
    localparam logic [4:0] OPC_DATA   = 5'b11011;

    typedef struct packed {
        logic [4:0]  decode;
        logic [63:0] data;
        logic        src_err;
        logic        dst_err;
        logic        opc_err;
        logic        unsup;
        logic        par_err;
    } entry_t;

    // Returns {needs_data, code}; code 0 means the pair is not a known message.
    function automatic logic [5:0] decode_lookup(input logic [7:0] msgcode, input logic [7:0] subcode);
        logic [5:0] res;
        res = 6'd0;
        case ({msgcode, subcode})
            16'h0301: res = {1'b0, 5'd1};
            16'h0309: res = {1'b0, 5'd2};
            16'h0401: res = {1'b0, 5'd3};
            16'h0409: res = {1'b0, 5'd4};
            16'h0900: res = {1'b0, 5'd5};
            16'h0901: res = {1'b0, 5'd6};
            16'h0902: res = {1'b0, 5'd7};
            16'h0100: res = {1'b1, 5'd8};
            default:  res = 6'd0;
        endcase
        return res;
    endfunction

`ifdef UCIE_SB_RX_PARITY_CHK_EN
    function automatic logic hdr_parity(input logic [63:0] hdr);
        return ^(hdr & 64'hFFFF_FFFF_3FFF_FFFF);
    endfunction

    function automatic logic data_parity(input logic [63:0] pay);
        return ^pay;
    endfunction
`endif

    function automatic entry_t build_entry(input logic [63:0] hdr, input logic [63:0] pay, input logic is_data);
        entry_t     e;
        logic [5:0] lk;
        lk        = decode_lookup(hdr[53:46], hdr[7:0]);
        e.data    = is_data ? pay : 64'd0;
        e.src_err = (hdr[63:61] != SRC_ID);
        e.dst_err = (hdr[26:24] != DST_ID);
        e.opc_err = (hdr[36:32] != OPC_NODATA) && (hdr[36:32] != OPC_DATA);
        if ((lk[4:0] != 5'd0) && (lk[5] == is_data)) begin
            e.decode = lk[4:0];
            e.unsup  = 1'b0;
        end else begin
            e.decode = 5'd0;
            e.unsup  = 1'b1;
        end
`ifdef UCIE_SB_RX_PARITY_CHK_EN
        e.par_err = (hdr[30] != hdr_parity(hdr)) || (is_data && (hdr[31] != data_parity(pay)));
`else
        e.par_err = 1'b0;
`endif
        return e;
    endfunction

    logic [127-N:0]  msg_r;
    logic [CW-1:0]   cnt_r;
    logic            is_data_r;
    logic [127:0]    nxt_msg_s;
    logic [4:0]      beat_opc_s;
    logic            cur_data_s;
    logic            last_s;
    logic            done_s;
    entry_t          entry_s;

    entry_t          mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [FW-1:0]   fill_r;
    logic            crd_r;
    logic            ovf_r;
    logic            vld_s;
    logic            full_s;
    logic            pop_s;
    logic            push_s;
    entry_t          head_s;

    // Beat assembly: message length is chosen from the opcode beat, then held in is_data_r.
    always_comb begin
        nxt_msg_s  = {msg_r, i_received_data};
        beat_opc_s = i_received_data[OP_LSB +: 5];
        if (cnt_r == CW'(OP_BEAT)) begin
            cur_data_s = (beat_opc_s == OPC_DATA);
        end else begin
            cur_data_s = is_data_r;
        end
        if (cur_data_s) begin
            last_s = (cnt_r == CW'(BEATS_MSG - 1));
        end else begin
            last_s = (cnt_r == CW'(BEATS_HDR - 1));
        end
        done_s = i_pl_cfg_vld && last_s;
        if (cur_data_s) begin
            entry_s = build_entry(nxt_msg_s[127:64], nxt_msg_s[63:0], 1'b1);
        end else begin
            entry_s = build_entry(nxt_msg_s[63:0], 64'd0, 1'b0);
        end
    end

    // Beat counter, shift register and latched message length.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            msg_r     <= '0;
            cnt_r     <= '0;
            is_data_r <= 1'b0;
        end else if (i_pl_cfg_vld) begin
            msg_r     <= nxt_msg_s[127-N:0];
            is_data_r <= cur_data_s;
            cnt_r     <= done_s ? '0 : cnt_r + CW'(1);
        end
    end

    // FIFO control: a pop in the completion cycle frees the slot for the incoming entry.
    always_comb begin
        vld_s  = (fill_r != '0);
        full_s = (fill_r == FW'(DEPTH));
        pop_s  = vld_s && i_msg_rdy;
        push_s = done_s && (!full_s || pop_s);
    end

    // Entry storage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Pointers, occupancy and the registered credit / overflow pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fill_r   <= '0;
            crd_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fill_r <= fill_r + FW'(1);
                2'b01:   fill_r <= fill_r - FW'(1);
                default: fill_r <= fill_r;
            endcase
            crd_r <= pop_s;
            ovf_r <= done_s && full_s && !pop_s;
        end
    end

    // Head entry presentation; fields read 0 while the buffer is empty.
    always_comb begin
        head_s    = mem_r[rd_ptr_r];
        o_msg_vld = vld_s;
        if (vld_s) begin
            o_rdi_pl_sb_decode       = head_s.decode;
            o_rdi_pl_adv_cap_value   = head_s.data;
            o_sb_src_error           = head_s.src_err;
            o_sb_dst_error           = head_s.dst_err;
            o_sb_opcode_error        = head_s.opc_err;
            o_sb_unsupported_message = head_s.unsup;
            o_sb_parity_error        = head_s.par_err;
        end else begin
            o_rdi_pl_sb_decode       = 5'd0;
            o_rdi_pl_adv_cap_value   = 64'd0;
            o_sb_src_error           = 1'b0;
            o_sb_dst_error           = 1'b0;
            o_sb_opcode_error        = 1'b0;
            o_sb_unsupported_message = 1'b0;
            o_sb_parity_error        = 1'b0;
        end
    end

    assign o_fill        = fill_r;
    assign o_cfg_crd     = crd_r;
    assign o_sb_overflow = ovf_r;

endmodule
